// File: rtl/pid_sweep_scheduler.sv
// pid_sweep_scheduler
//
// Shares one PID datapath across NUM_MOTORS channels. Every control period
// (internal divider tick) or external trigger starts a sweep over channels
// 0..NUM_MOTORS-1. Each channel takes four cycles: FETCH (latch the register
// bank values for ch_sel), ERR (saturated error, integral update), MUL
// (P and I products), OUT (saturated duty, strobe on the following cycle).
//
// Ports:
//   CLK, reset         clock, asynchronous active-high reset
//   enable             sweeps allowed; low clears all integrals and aborts
//   trigger            one-cycle pulse requesting an immediate sweep
//   ch_sel             channel whose values the register bank presents
//   setpoint .. IntegralLimit  signed 24-bit values for channel ch_sel
//   duty, duty_ch      saturated output and its channel (held between strobes)
//   duty_valid         one-cycle strobe qualifying duty/duty_ch
//   busy               sweep in progress
//   overrun            sticky: start request seen while busy
//
// Build option: define PID_DEADBAND_EN to zero |err| <= deadband before the
// integral update and products. Without it the deadband input is ignored.
module pid_sweep_scheduler #(
    parameter int NUM_MOTORS = 4,
    parameter int TICK_DIV   = 1000,
    localparam int CH_W  = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1,
    localparam int CNT_W = $clog2(TICK_DIV)
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                enable,
    input  logic                trigger,
    output logic [CH_W-1:0]     ch_sel,
    input  logic signed [23:0]  setpoint,
    input  logic signed [23:0]  state,
    input  logic signed [23:0]  Kp,
    input  logic signed [23:0]  Ki,
    input  logic signed [23:0]  deadband,
    input  logic signed [23:0]  PWMLimit,
    input  logic signed [23:0]  IntegralLimit,
    output logic signed [23:0]  duty,
    output logic [CH_W-1:0]     duty_ch,
    output logic                duty_valid,
    output logic                busy,
    output logic                overrun
);

    typedef enum logic [2:0] {IDLE, FETCH, ERR, MUL, OUT} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [23:0] sp_q, sp_d, st_q, st_d, kp_q, kp_d, ki_q, ki_d;
    logic signed [23:0] pl_q, pl_d, il_q, il_d;
    logic signed [23:0] err_q, err_d;
    logic signed [23:0] integ_q [NUM_MOTORS];
    logic signed [23:0] integ_d [NUM_MOTORS];
    logic signed [47:0] p_q, p_d, i_q, i_d;
    logic signed [23:0] duty_q, duty_d;
    logic [CH_W-1:0]    duty_ch_q, duty_ch_d;
    logic               duty_valid_q, duty_valid_d;
    logic               overrun_q, overrun_d;

    logic               tick, start_req;
    logic signed [24:0] err_raw;
    logic signed [23:0] err_sat, err_use, integ_cur, il_pos, integ_new;
    logic signed [25:0] int_sum, int_lim;
    logic signed [23:0] pl_pos, duty_sat;
    logic signed [48:0] pid_sum, pwm_lim;

`ifdef PID_DEADBAND_EN
    logic signed [23:0] db_q, db_d;
    logic signed [24:0] abs_err, db_ext;
`else
    logic unused_deadband;
    assign unused_deadband = ^deadband;
`endif

    // Arithmetic on the latched operands; the FSM picks which result to keep.
    always_comb begin : datapath
        err_raw = {sp_q[23], sp_q} - {st_q[23], st_q};
        // Top two bits differ only when the 25-bit difference leaves 24-bit range.
        if (err_raw[24] != err_raw[23])
            err_sat = err_raw[24] ? 24'sh800000 : 24'sh7fffff;
        else
            err_sat = err_raw[23:0];

`ifdef PID_DEADBAND_EN
        abs_err = err_sat[23] ? -{err_sat[23], err_sat} : {err_sat[23], err_sat};
        db_ext  = {db_q[23], db_q};
        err_use = (abs_err <= db_ext) ? 24'sd0 : err_sat;
`else
        err_use = err_sat;
`endif

        integ_cur = integ_q[ch_q];
        int_sum   = {{2{integ_cur[23]}}, integ_cur} + {{2{err_use[23]}}, err_use};
        // A negative limit collapses the allowed window to exactly zero.
        il_pos    = il_q[23] ? 24'sd0 : il_q;
        int_lim   = {2'b00, il_pos};
        if (int_sum > int_lim)
            integ_new = il_pos;
        else if (int_sum < -int_lim)
            integ_new = -il_pos;
        else
            integ_new = int_sum[23:0];

        pid_sum = {p_q[47], p_q} + {i_q[47], i_q};
        pl_pos  = pl_q[23] ? 24'sd0 : pl_q;
        pwm_lim = {25'b0, pl_pos};
        if (pid_sum > pwm_lim)
            duty_sat = pl_pos;
        else if (pid_sum < -pwm_lim)
            duty_sat = -pl_pos;
        else
            duty_sat = pid_sum[23:0];
    end

    always_comb begin : control
        tick         = (cnt_q == CNT_W'(TICK_DIV - 1));
        start_req    = tick | trigger;
        cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
        fsm_d        = fsm_q;
        ch_d         = ch_q;
        sp_d         = sp_q;
        st_d         = st_q;
        kp_d         = kp_q;
        ki_d         = ki_q;
        pl_d         = pl_q;
        il_d         = il_q;
`ifdef PID_DEADBAND_EN
        db_d         = db_q;
`endif
        err_d        = err_q;
        integ_d      = integ_q;
        p_d          = p_q;
        i_d          = i_q;
        duty_d       = duty_q;
        duty_ch_d    = duty_ch_q;
        duty_valid_d = 1'b0;
        // Requests arriving mid-sweep are never queued, only flagged.
        overrun_d    = overrun_q | (start_req && (fsm_q != IDLE));

        if (!enable) begin
            for (int i = 0; i < NUM_MOTORS; i++)
                integ_d[i] = '0;
            fsm_d = IDLE;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (start_req) begin
                        ch_d  = '0;
                        fsm_d = FETCH;
                    end
                end
                FETCH: begin
                    sp_d  = setpoint;
                    st_d  = state;
                    kp_d  = Kp;
                    ki_d  = Ki;
                    pl_d  = PWMLimit;
                    il_d  = IntegralLimit;
`ifdef PID_DEADBAND_EN
                    db_d  = deadband;
`endif
                    fsm_d = ERR;
                end
                ERR: begin
                    err_d         = err_use;
                    integ_d[ch_q] = integ_new;
                    fsm_d         = MUL;
                end
                MUL: begin
                    // integ_q already holds this channel's fresh integral.
                    p_d   = 48'(kp_q) * 48'(err_q);
                    i_d   = 48'(ki_q) * 48'(integ_q[ch_q]);
                    fsm_d = OUT;
                end
                OUT: begin
                    duty_d       = duty_sat;
                    duty_ch_d    = ch_q;
                    duty_valid_d = 1'b1;
                    if (ch_q == CH_W'(NUM_MOTORS - 1))
                        fsm_d = IDLE;
                    else begin
                        ch_d  = ch_q + CH_W'(1);
                        fsm_d = FETCH;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            fsm_q        <= IDLE;
            ch_q         <= '0;
            cnt_q        <= '0;
            sp_q         <= '0;
            st_q         <= '0;
            kp_q         <= '0;
            ki_q         <= '0;
            pl_q         <= '0;
            il_q         <= '0;
`ifdef PID_DEADBAND_EN
            db_q         <= '0;
`endif
            err_q        <= '0;
            p_q          <= '0;
            i_q          <= '0;
            duty_q       <= '0;
            duty_ch_q    <= '0;
            duty_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            sp_q         <= sp_d;
            st_q         <= st_d;
            kp_q         <= kp_d;
            ki_q         <= ki_d;
            pl_q         <= pl_d;
            il_q         <= il_d;
`ifdef PID_DEADBAND_EN
            db_q         <= db_d;
`endif
            err_q        <= err_d;
            p_q          <= p_d;
            i_q          <= i_d;
            duty_q       <= duty_d;
            duty_ch_q    <= duty_ch_d;
            duty_valid_q <= duty_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    for (genvar gi = 0; gi < NUM_MOTORS; gi++) begin : g_integ
        always_ff @(posedge CLK or posedge reset) begin
            if (reset)
                integ_q[gi] <= '0;
            else
                integ_q[gi] <= integ_d[gi];
        end
    end

    assign ch_sel     = ch_q;
    assign duty       = duty_q;
    assign duty_ch    = duty_ch_q;
    assign duty_valid = duty_valid_q;
    assign busy       = (fsm_q != IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pid_sweep_scheduler.sv
// Testbench for pid_sweep_scheduler: directed scenarios followed by random
// register-bank contents, triggers and enable drops. Expected outputs come
// from a timing model (strobe at T+5+4k, busy T+1..T+4N) plus plain integer
// PID arithmetic on the bank values.
module tb_pid_sweep_scheduler;
    localparam int N  = 4;
    localparam int TD = 2000;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic trigger = 1'b0;
    logic [1:0] ch_sel, duty_ch;
    logic signed [23:0] setpoint, state, Kp, Ki, deadband, PWMLimit, IntegralLimit, duty;
    logic duty_valid, busy, overrun;

    // Register bank contents per channel.
    longint sp_b[N], st_b[N], kp_b[N], ki_b[N], db_b[N], pl_b[N], il_b[N];

    // Reference model state.
    longint integ_m[N];
    longint pend, last_duty;
    int     last_ch, t0, cyc, t_sweep;
    bit     active, exp_valid, ovr_m;

    int tests, fails;
    longint cap_duty[$];
    int     cap_ch[$], cap_t[$];

    pid_sweep_scheduler #(.NUM_MOTORS(N), .TICK_DIV(TD)) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .trigger(trigger),
        .ch_sel(ch_sel), .setpoint(setpoint), .state(state), .Kp(Kp), .Ki(Ki),
        .deadband(deadband), .PWMLimit(PWMLimit), .IntegralLimit(IntegralLimit),
        .duty(duty), .duty_ch(duty_ch), .duty_valid(duty_valid),
        .busy(busy), .overrun(overrun)
    );

    assign setpoint      = 24'(sp_b[ch_sel]);
    assign state         = 24'(st_b[ch_sel]);
    assign Kp            = 24'(kp_b[ch_sel]);
    assign Ki            = 24'(ki_b[ch_sel]);
    assign deadband      = 24'(db_b[ch_sel]);
    assign PWMLimit      = 24'(pl_b[ch_sel]);
    assign IntegralLimit = 24'(il_b[ch_sel]);

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint clampl(input longint v, input longint lo, input longint hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Whole PID computation for channel k from its bank values.
    task automatic model_pid(input int k);
        longint e, il, pl;
        e = clampl(sp_b[k] - st_b[k], -64'sd8388608, 64'sd8388607);
`ifdef PID_DEADBAND_EN
        if (((e < 0) ? -e : e) <= db_b[k]) e = 0;
`endif
        il = (il_b[k] < 0) ? 0 : il_b[k];
        integ_m[k] = clampl(integ_m[k] + e, -il, il);
        pl = (pl_b[k] < 0) ? 0 : pl_b[k];
        pend = clampl(kp_b[k] * e + ki_b[k] * integ_m[k], -pl, pl);
    endtask

    // Advance the model across the clock edge that ends cycle c.
    task automatic model_edge(input int c);
        bit busy_now, req;
        int off, k;
        req = (trigger === 1'b1) || (c % TD == TD - 1);
        busy_now = active;
        exp_valid = 1'b0;
        if (enable !== 1'b1) begin
            foreach (integ_m[i]) integ_m[i] = 0;
            active = 1'b0;
        end else if (busy_now) begin
            off = c - t0 - 1;
            k = off / 4;
            if (off % 4 == 1) model_pid(k);
            if (off % 4 == 3) begin
                exp_valid = 1'b1;
                last_duty = pend;
                last_ch = k;
                if (k == N - 1) active = 1'b0;
            end
        end
        if (req) begin
            if (busy_now) ovr_m = 1'b1;
            else if (enable === 1'b1) begin
                active = 1'b1;
                t0 = c;
            end
        end
    endtask

    task automatic check_cycle(input int c);
        chk("duty_valid", duty_valid, exp_valid);
        chk("duty", duty, last_duty);
        chk("duty_ch", duty_ch, last_ch);
        chk("busy", busy, active);
        chk("overrun", overrun, ovr_m);
        if (active && ((c - t0 - 1) % 4 == 0))
            chk("ch_sel", ch_sel, (c - t0 - 1) / 4);
        if (duty_valid === 1'b1) begin
            cap_duty.push_back(duty);
            cap_ch.push_back(duty_ch);
            cap_t.push_back(c);
        end
    endtask

    task automatic step(input bit trig);
        trigger = trig;
        @(posedge CLK);
        model_edge(cyc);
        cyc++;
        @(negedge CLK);
        check_cycle(cyc);
        trigger = 1'b0;
    endtask

    task automatic quiet();
        int n = 0;
        while ((active || (cyc % TD) > TD - 30) && n < 4 * TD) begin
            step(1'b0);
            n++;
        end
        chk("quiet_bound", active, 0);
    endtask

    task automatic clear_caps();
        cap_duty.delete();
        cap_ch.delete();
        cap_t.delete();
    endtask

    task automatic sweep();
        quiet();
        clear_caps();
        t_sweep = cyc;
        step(1'b1);
        repeat (4 * N + 1) step(1'b0);
    endtask

    task automatic chk_sweep(input string tag, input longint exp_duty);
        chk({tag, "_count"}, cap_duty.size(), 4);
        for (int k = 0; k < cap_duty.size() && k < N; k++) begin
            chk({tag, "_duty"}, cap_duty[k], exp_duty);
            chk({tag, "_ch"}, cap_ch[k], k);
            chk({tag, "_time"}, cap_t[k], t_sweep + 5 + 4 * k);
        end
    endtask

    task automatic set_all(input longint sp, st, kp, ki, db, pl, il);
        for (int k = 0; k < N; k++) begin
            sp_b[k] = sp; st_b[k] = st; kp_b[k] = kp; ki_b[k] = ki;
            db_b[k] = db; pl_b[k] = pl; il_b[k] = il;
        end
    endtask

    function automatic longint r24();
        logic signed [23:0] v;
        v = 24'($urandom);
        return longint'(v);
    endfunction

    function automatic longint rsm(input int m);
        return longint'($urandom_range(0, 2 * m)) - m;
    endfunction

    task automatic model_reset();
        foreach (integ_m[i]) integ_m[i] = 0;
        active = 1'b0; exp_valid = 1'b0; ovr_m = 1'b0;
        last_duty = 0; last_ch = 0; pend = 0; t0 = 0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_duty_valid"}, duty_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_duty"}, duty, 0);
        chk({tag, "_duty_ch"}, duty_ch, 0);
        chk({tag, "_ch_sel"}, ch_sel, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int expv[3];
        int n;
        tests = 0; fails = 0; cyc = 0; t_sweep = 0;
        set_all(0, 0, 0, 0, 0, 0, 0);
        model_reset();

        repeat (2) @(negedge CLK);
        chk_outputs_zero("reset");
        reset = 1'b0;
        cyc = 0;

        // Proportional only: err=60, Kp=2 on every channel.
        set_all(100, 40, 2, 0, 0, 1000, 0);
        sweep();
        chk_sweep("p_only", 120);

        // Integral only, saturating at IntegralLimit=25.
        expv = '{10, 20, 25};
        set_all(10, 0, 0, 1, 0, 1000, 25);
        for (int s = 0; s < 3; s++) begin
            sweep();
            chk("integ_count", cap_duty.size(), 4);
            chk("integ_ch0_duty", cap_duty[0], expv[s]);
        end

        // Output saturation at +/-PWMLimit.
        set_all(5000, 0, 1000, 0, 0, 4095, 0);
        sweep();
        chk_sweep("sat_pos", 4095);
        set_all(-5000, 0, 1000, 0, 0, 4095, 0);
        sweep();
        chk_sweep("sat_neg", -4095);

`ifdef PID_DEADBAND_EN
        set_all(5, 0, 3, 0, 0, 1000, 100);
        sweep();
        chk_sweep("db_off", 15);
        set_all(5, 0, 3, 0, 8, 1000, 100);
        sweep();
        chk_sweep("db_inside", 0);
        set_all(5, 0, 0, 1, 8, 1000, 100);
        sweep();
        chk_sweep("db_integ_frozen", 5);
        set_all(9, 0, 3, 0, 8, 1000, 100);
        sweep();
        chk_sweep("db_outside", 27);
`endif

        // Trigger 3 cycles into a sweep, then at T+4N+1.
        chk("overrun_pre", overrun, 0);
        quiet();
        clear_caps();
        t_sweep = cyc;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        repeat (13) step(1'b0);
        chk("overrun_strobes", cap_duty.size(), 4);
        chk("overrun_set", overrun, 1);
        step(1'b1);
        chk("restart_busy", busy, 1);
        repeat (4 * N + 1) step(1'b0);
        chk("overrun_sticky", overrun, 1);

        // Enable dropped after the channel-1 strobe.
        set_all(10, 0, 0, 1, 0, 1000, 1000);
        quiet();
        clear_caps();
        step(1'b1);
        repeat (8) step(1'b0);
        enable = 1'b0;
        repeat (12) step(1'b0);
        enable = 1'b1;
        chk("enable_drop_strobes", cap_duty.size(), 2);
        sweep();
        chk_sweep("integ_cleared", 10);

        // Random bank contents, triggers and enable glitches; ticks included.
        for (int it = 0; it < 60; it++) begin
            n = 0;
            while (active && n < 100) begin
                step(1'b0);
                n++;
            end
            chk("rand_idle_bound", active, 0);
            for (int k = 0; k < N; k++) begin
                sp_b[k] = $urandom_range(0, 1) ? r24() : rsm(3000);
                st_b[k] = $urandom_range(0, 1) ? r24() : rsm(3000);
                kp_b[k] = $urandom_range(0, 1) ? r24() : rsm(50);
                ki_b[k] = $urandom_range(0, 1) ? r24() : rsm(20);
                db_b[k] = rsm(40);
                pl_b[k] = $urandom_range(0, 1) ? r24() : rsm(5000);
                il_b[k] = $urandom_range(0, 1) ? r24() : rsm(5000);
            end
            for (int s = 0; s < 35; s++) begin
                enable = ($urandom_range(0, 49) != 0);
                step($urandom_range(0, 7) == 0);
            end
            enable = 1'b1;
        end

        // Asynchronous reset in the middle of a sweep.
        set_all(100, 40, 2, 0, 0, 1000, 0);
        quiet();
        step(1'b1);
        repeat (6) step(1'b0);
        #2 reset = 1'b1;
        #1 chk_outputs_zero("async_reset");
        model_reset();
        @(negedge CLK);
        reset = 1'b0;
        cyc = 0;
        // Runs past the first internal tick at cycle TD-1.
        repeat (TD + 30) step(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pid_sweep_scheduler.md
# pid_sweep_scheduler

Time-multiplexes one PID arithmetic datapath across NUM_MOTORS motor channels of the motor board. On every control-period tick (internal divider or external trigger) it sweeps channels 0..NUM_MOTORS-1 in order: it fetches setpoint, state and gains, updates that channel's private integral and emits one saturated duty word per channel. It sits between the per-motor register bank (gains, limits, setpoints, encoder state) and the PWM generators, which latch `duty` on `duty_valid`.

## Interface
- NUM_MOTORS, 4: channels served per sweep, 1..16.
- TICK_DIV, 1000: clocks per internal control period; must be ≥ 4*NUM_MOTORS+1.
- CLK  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  high: sweeps allowed; low: integrals cleared, no sweeps.
- trigger  in  1  one-cycle pulse starting a sweep immediately (in addition to the internal tick).
- ch_sel  out  clog2(NUM_MOTORS)  channel whose inputs the register bank must present.
- setpoint, state, Kp, Ki, deadband, PWMLimit, IntegralLimit  in  24 each, signed  values for channel `ch_sel`, valid combinationally in the same cycle.
- duty  out  24 signed  saturated controller output.
- duty_ch  out  clog2(NUM_MOTORS)  channel that `duty` belongs to.
- duty_valid  out  1  one-cycle strobe qualifying `duty` and `duty_ch`.
- busy  out  1  high while a sweep is in progress.
- overrun  out  1  sticky; set when a start request arrives while busy; cleared only by reset.

## Operation
- Start request = internal tick OR `trigger`. Internal tick is asserted when the period counter equals TICK_DIV-1; the counter then wraps to 0. The counter runs regardless of `enable`.
- FSM states: IDLE, FETCH, ERR, MUL, OUT.
- IDLE: on a start request with `enable`=1, set ch=0 and go to FETCH. With `enable`=0 the request is dropped without setting `overrun`.
- FETCH: drive `ch_sel`=ch; register setpoint, state, Kp, Ki, deadband, PWMLimit and IntegralLimit at the end of the cycle. Go to ERR.
- ERR: err = setpoint − state, computed in 25 bits and saturated to 24-bit signed. Then integral[ch] ← sat(integral[ch] + err, ±IntegralLimit), with the sum held in 26 bits before saturation. Go to MUL.
- MUL: p = Kp*err and i = Ki*integral[ch], both 48-bit signed, using the freshly updated integral. Go to OUT.
- OUT: sum = p + i in 49 bits; duty ← sum saturated to [−PWMLimit, +PWMLimit]. Set `duty_ch`=ch. If ch = NUM_MOTORS-1, go to IDLE; otherwise increment ch and go to FETCH.
- A start request while busy sets `overrun` and is ignored; the sweep in progress is unaffected.
- `enable` falling during a sweep: the FSM returns to IDLE next cycle with no further `duty_valid`, and all integrals are held at 0 while `enable`=0.
- Negative PWMLimit or IntegralLimit values are treated as 0, which forces the clamped result to 0.
- Reset values: state IDLE, ch_sel=0, duty=0, duty_ch=0, duty_valid=0, busy=0, overrun=0, all integrals 0, period counter 0.

## Timing
- Start request in cycle T: FETCH for channel k occupies cycle T+1+4k.
- `duty_valid` for channel k is high in cycle T+5+4k, for exactly one cycle.
- A full sweep takes 4*NUM_MOTORS cycles; `busy` is high from T+1 through T+4*NUM_MOTORS inclusive.
- A new request in cycle T+4*NUM_MOTORS counts as overrun. A request in cycle T+4*NUM_MOTORS+1 starts a new sweep.
- `duty` and `duty_ch` hold their last values between strobes.
- The first internal tick after reset release is in cycle TICK_DIV-1.
- Asynchronous reset mid-sweep: all outputs take their reset values immediately, and no partial `duty_valid` is issued.

## Configuration
- PID_DEADBAND_EN defined: in ERR, if |err| ≤ deadband, err is forced to 0 before the integral update and the products, so the integral is frozen and the P term is 0.
- PID_DEADBAND_EN undefined: the `deadband` input is ignored, and err is used unmodified.

## Test plan
- NUM_MOTORS=4, Kp=2, Ki=0, setpoint=100, state=40 on all channels, `trigger` at T -> four strobes at T+5, T+9, T+13, T+17 with duty=120 and duty_ch=0,1,2,3.
- Kp=0, Ki=1, err=10, IntegralLimit=25, PWMLimit=1000, three sweeps -> channel-0 duty = 10, 20, 25 (integral saturates at 25).
- Kp=1000, err=5000, PWMLimit=4095 -> duty=4095; err=−5000 -> duty=−4095.
- `trigger` pulsed again 3 cycles into a sweep -> `overrun`=1 and stays 1, strobe count still 4; `trigger` at T+4*NUM_MOTORS+1 -> new sweep starts.
- `enable` dropped after the channel-1 strobe -> no strobes for channels 2 and 3, integrals read 0 on the next sweep. `reset` pulsed mid-sweep -> all outputs 0 and FSM idle.
- With PID_DEADBAND_EN defined: deadband=8, err=5, Kp=3 -> duty=0 and the integral is unchanged; err=9 -> duty=27.
